// File: rtl/life_pkg.sv
// Shared types and constants for the 7x7 Life display path.
package life_pkg;
  localparam int GRID_N    = 7;
  localparam int GRID_BITS = 49;
  localparam int POP_W     = 6;
  localparam int ROW_W     = 3;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_LIT = 2'd1,
    ST_GAP = 2'd2
  } scan_state_e;

  // Flat bit index of cell (row r, column c).
  function automatic logic [5:0] cell_idx(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] c);
    return 6'(GRID_N * int'(r) + int'(c));
  endfunction
endpackage

// File: rtl/grid_scan_driver_if.sv
// Grid input / LED matrix output bundle between the Life datapath and the scan driver.
interface grid_scan_if;
  import life_pkg::*;

  logic [GRID_BITS-1:0] grid;
  logic                 grid_valid;
  logic                 blank;
  logic [GRID_N-1:0]    row_sel;
  logic [GRID_N-1:0]    col_data;
  logic                 frame_start;
  logic [POP_W-1:0]     pop_count;
  logic                 extinct;

  modport master (output grid, grid_valid, blank,
                  input  row_sel, col_data, frame_start, pop_count, extinct);
  modport slave  (input  grid, grid_valid, blank,
                  output row_sel, col_data, frame_start, pop_count, extinct);
endinterface

// File: rtl/grid_popcount.sv
// Combinational live-cell count of a 49-bit grid.
module grid_popcount
  import life_pkg::*;
(
  input  logic [GRID_BITS-1:0] bits_i,
  output logic [POP_W-1:0]     count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < GRID_BITS; i++) count_o = count_o + POP_W'(bits_i[i]);
  end
endmodule

// File: rtl/grid_scan_driver.sv
// Row-multiplexed 7x7 LED driver with tear-free frame swap and population status.
module grid_scan_driver
  import life_pkg::*;
#(
  parameter int ROW_DWELL  = 1000,
  parameter int GAP_CYCLES = 8,
  parameter int DWELL_W    = 10
) (
  input  logic        clka,
  input  logic        rst_n,
  grid_scan_if.slave  bus
);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
  localparam logic [DWELL_W-1:0] GAP_LAST   = DWELL_W'(GAP_CYCLES - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(GRID_N - 1);

  scan_state_e          state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 swap;
  logic [GRID_BITS-1:0] pending_q, pending_d, display_q, display_d;
  logic                 pend_flag_q, pend_flag_d;
  logic [GRID_N-1:0]    row_sel_q, row_sel_d, col_data_q, col_data_d;
  logic                 frame_start_q, frame_start_d;
  logic [POP_W-1:0]     pop_w, pop_q;
  logic                 extinct_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    swap    = 1'b0;
    if (bus.blank) begin
      state_d = ST_OFF;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_LIT;
          row_d   = '0;
          cnt_d   = '0;
          swap    = 1'b1;
        end
        ST_LIT: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_LIT;
            cnt_d   = '0;
            // Wrapping past the last row is the frame boundary.
            if (row_q == LAST_ROW) begin
              row_d = '0;
              swap  = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // A strobe on the swap edge lands in pending; the swap itself takes the old value.
  always_comb begin
    pending_d     = bus.grid_valid ? bus.grid : pending_q;
    pend_flag_d   = bus.grid_valid ? 1'b1 : (swap ? 1'b0 : pend_flag_q);
    display_d     = (swap && pend_flag_q) ? pending_q : display_q;
    frame_start_d = swap;
    row_sel_d     = '0;
    col_data_d    = '0;
    if (state_d == ST_LIT) begin
      row_sel_d  = GRID_N'(1) << row_d;
      col_data_d = display_d[cell_idx(row_d, '0) +: GRID_N];
    end
  end

  grid_popcount u_pop (
    .bits_i  (display_q),
    .count_o (pop_w)
  );

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      row_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= '0;
      pend_flag_q   <= 1'b0;
      display_q     <= '0;
      row_sel_q     <= '0;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
      pop_q         <= '0;
      extinct_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      pend_flag_q   <= pend_flag_d;
      display_q     <= display_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
      pop_q         <= pop_w;
      extinct_q     <= (pop_w == '0);
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.col_data    = col_data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pop_count   = pop_q;
  assign bus.extinct     = extinct_q;
endmodule

// File: doc/grid_scan_driver.md
Name: grid_scan_driver

Overview:
- Downstream consumer of the 7x7 Life datapath's 49-bit `grid`; drives a multiplexed 7x7 LED matrix one row at a time.
- Captures each new generation without tearing: a new grid reaches the display only at a frame boundary.
- Reports live-cell population and an extinction flag for the status display and the top-level controller.

Parameters:
- ROW_DWELL, 1000, clock cycles a row stays lit (must be >= 2).
- GAP_CYCLES, 8, blanking cycles between rows to suppress ghosting (must be >= 1).
- DWELL_W, 10, width of the dwell/gap counter (must hold max(ROW_DWELL, GAP_CYCLES)-1).

Ports:
- clka  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- grid  in  49  cell state from the datapath; bit 7*r+c = row r, column c; 1 = alive.
- grid_valid  in  1  single-cycle strobe: `grid` holds a newly committed generation.
- blank  in  1  level; forces all rows off (used during PROGRAM/idle).
- row_sel  out  7  one-hot active-high row enable; 0 = all rows off.
- col_data  out  7  column data for the lit row; bit c = column c.
- frame_start  out  1  one-cycle pulse when row 0 is lit with a freshly swapped frame.
- pop_count  out  6  live cells in the displayed frame (0..49).
- extinct  out  1  high when pop_count == 0.

Behaviour:
- Reset (async, rst_n low):
  - row_sel=0, col_data=0, frame_start=0, pop_count=0, extinct=1.
  - pending and display registers = 0, pend_flag=0, row index=0, counter=0, FSM=OFF.
- Storage: pending[48:0], pend_flag, display[48:0].
  - grid_valid loads `grid` into pending and sets pend_flag.
  - A later grid_valid before the swap overwrites pending; only the newest is kept.
- FSM states OFF, LIT, GAP:
  - OFF: row_sel=0. When blank=0, go to LIT at row 0 with a frame swap.
  - LIT: row_sel = 1<<row, col_data = display[7*row +: 7]. After ROW_DWELL cycles go to GAP.
  - GAP: row_sel=0, col_data=0 for GAP_CYCLES cycles. Then row = (row==6) ? 0 : row+1 and go to LIT.
  - Wrap from row 6 to row 0 is a frame boundary and performs a frame swap.
- Frame swap (on entry to LIT at row 0):
  - If pend_flag: display<=pending, pend_flag<=0, frame_start pulses on the first LIT cycle of row 0.
  - Otherwise display is unchanged and frame_start still pulses.
  - grid_valid in the same cycle as the swap: the swap takes the old pending value; the new grid goes to pending and pend_flag stays 1.
- blank:
  - blank=1 in any state moves to OFF on the next edge; row_sel=0 and col_data=0 from that edge on.
  - The row index resets to 0 and the counter is cleared.
  - Capture into pending continues while blanked.
- Outputs are registered; row_sel/col_data change on the same edge as the FSM state.
- Population:
  - pop_count is registered, one cycle after display changes.
  - Computed as the sum of 49 bits, 6-bit result, no overflow possible.
  - extinct is registered alongside pop_count.
- Mid-operation reset: all state is cleared immediately; after release the block starts in OFF and needs blank=0 to resume.

Decomposition:
- Shared package `life_pkg`:
  - GRID_N=7 and GRID_BITS=49.
  - The row-slice index function (7*r+c).
  - FSM state encoding {OFF, LIT, GAP}.
  - POP_W=6.
- One natural sub-module, `grid_popcount`: combinational 49-bit population count, 6-bit output; the parent registers its result.
- The FSM and counter stay in the parent.

Test Plan (ROW_DWELL=4, GAP_CYCLES=1, DWELL_W=3):
1. Reset, blank=0, grid=0 -> row_sel: 0000001 for 4 cycles, then 0 for 1 cycle, then 0000010; a full frame is 35 cycles; frame_start pulses every 35 cycles; extinct=1.
2. grid_valid with grid=49'h1 -> no change mid-frame; at the next frame_start row 0 shows col_data=0000001; pop_count=1 one cycle later; extinct=0.
3. Glider pattern (bits 1, 9, 14, 15, 16) loaded -> row 0 col_data=0000010, row 1 0000100, row 2 0000111; pop_count=5.
4. Two grid_valid strobes in one frame (all-ones, then 49'h0) -> the displayed frame is 0; pop_count=0 (never 49).
5. grid_valid coincident with a swap edge -> the swap shows the previous pending value; the new value appears exactly one frame (35 cycles) later.
6. blank=1 during row 3, then release after 10 cycles -> row_sel=0 the next cycle; after release, row_sel=0000001 with a frame_start pulse. Separately, rst_n low mid-LIT -> all outputs 0 and extinct=1 asynchronously.
